// File: rtl/booth_mult_seq.sv
// rtl/booth_mult_seq.sv - sequential radix-4 Booth signed multiplier with CLA accumulator
module booth_cla_group #(
    parameter int GW = 4
) (
    input  logic [GW-1:0] a,
    input  logic [GW-1:0] b,
    input  logic          cin,
    output logic [GW-1:0] s,
    output logic          cout
);
    logic [GW-1:0] g;
    logic [GW-1:0] p;
    logic [GW:0]   c;
    logic          prop;

    // Every carry is a flat sum-of-products of generates, propagates and cin.
    always_comb begin
        g    = a & b;
        p    = a ^ b;
        c    = '0;
        prop = 1'b1;
        c[0] = cin;
        for (int i = 1; i <= GW; i++) begin
            prop = 1'b1;
            for (int k = 0; k < i; k++) begin
                prop = prop & p[k];
            end
            c[i] = cin & prop;
            for (int j = 0; j < i; j++) begin
                prop = 1'b1;
                for (int k = j + 1; k < i; k++) begin
                    prop = prop & p[k];
                end
                c[i] = c[i] | (g[j] & prop);
            end
        end
    end

    assign s    = p ^ c[GW-1:0];
    assign cout = c[GW];
endmodule

module booth_cla_add #(
    parameter int N = 34
) (
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         cin,
    output logic [N-1:0] s,
    output logic         cout
);
    localparam int NG = (N + 3) / 4;

    logic [NG:0] gc;

    assign gc[0] = cin;
    assign cout  = gc[NG];

    for (genvar k = 0; k < NG; k++) begin : g_grp
        localparam int LO = 4 * k;
        localparam int GW = (k == NG - 1) ? (N - 4 * (NG - 1)) : 4;
        booth_cla_group #(.GW(GW)) u_grp (
            .a    (a[LO+GW-1:LO]),
            .b    (b[LO+GW-1:LO]),
            .cin  (gc[k]),
            .s    (s[LO+GW-1:LO]),
            .cout (gc[k+1])
        );
    end
endmodule

module booth_mult_seq #(
    parameter int WIDTH = 32
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             ctrl_mult,
    input  logic [WIDTH-1:0] data_operandA,
    input  logic [WIDTH-1:0] data_operandB,
    output logic [WIDTH-1:0] data_result,
    output logic             data_exception,
    output logic             data_resultRDY,
    output logic             busy
);
    localparam int ITER = WIDTH / 2;
    localparam int AW   = WIDTH + 2;
    localparam int PW   = 2 * WIDTH + 3;
    localparam int CW   = (ITER > 1) ? $clog2(ITER) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [CW-1:0]    counter_q, counter_d;
    logic [PW-1:0]    p_q, p_d;
    logic [AW-1:0]    m_q, m_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             exception_q, exception_d;

    logic [AW-1:0]    acc;
    logic [AW-1:0]    addend;
    logic             add_cin;
    logic [AW-1:0]    sum;
    logic             add_cout_unused;
    logic [PW-1:0]    p_shift;
    logic [WIDTH:0]   prod_hi;
    logic             accept;

    assign acc = p_q[PW-1:WIDTH+1];

    // Recode {Q[1], Q[0], q_-1}; subtraction is one's complement plus carry-in.
    always_comb begin
        addend  = '0;
        add_cin = 1'b0;
        unique case (p_q[2:0])
            3'b001, 3'b010: addend = m_q;
            3'b011:         addend = {m_q[AW-2:0], 1'b0};
            3'b100: begin
                addend  = ~{m_q[AW-2:0], 1'b0};
                add_cin = 1'b1;
            end
            3'b101, 3'b110: begin
                addend  = ~m_q;
                add_cin = 1'b1;
            end
            default:        addend = '0;
        endcase
    end

    booth_cla_add #(.N(AW)) u_add (
        .a    (acc),
        .b    (addend),
        .cin  (add_cin),
        .s    (sum),
        .cout (add_cout_unused)
    );

    assign p_shift = {sum[AW-1], sum[AW-1], sum, p_q[WIDTH:2]};
    assign prod_hi = p_shift[2*WIDTH:WIDTH];

    always_comb begin
        state_d     = state_q;
        counter_d   = counter_q;
        p_d         = p_q;
        m_d         = m_q;
        result_d    = result_q;
        exception_d = exception_q;
        accept      = 1'b0;

        unique case (state_q)
            IDLE: accept = ctrl_mult;
            RUN: begin
                p_d = p_shift;
                if (counter_q == CW'(ITER - 1)) begin
                    state_d     = DONE;
                    counter_d   = '0;
                    result_d    = p_shift[WIDTH:1];
                    exception_d = ~((&prod_hi) | ~(|prod_hi));
                end else begin
                    counter_d = counter_q + 1'b1;
                end
            end
            DONE: begin
                accept  = ctrl_mult;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        if (accept) begin
            state_d   = RUN;
            counter_d = '0;
            m_d       = {{2{data_operandA[WIDTH-1]}}, data_operandA};
            p_d       = {{AW{1'b0}}, data_operandB, 1'b0};
        end
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            counter_q   <= '0;
            p_q         <= '0;
            m_q         <= '0;
            result_q    <= '0;
            exception_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            counter_q   <= counter_d;
            p_q         <= p_d;
            m_q         <= m_d;
            result_q    <= result_d;
            exception_q <= exception_d;
        end
    end

    assign data_result    = result_q;
    assign data_exception = exception_q;
    assign data_resultRDY = (state_q == DONE);
    assign busy           = (state_q == RUN);
endmodule

// File: tb/tb_booth_mult_seq.sv
// tb/tb_booth_mult_seq.sv - directed self-checking bench for booth_mult_seq
module tb_booth_mult_seq;
    logic        clock;
    logic        reset_n;
    logic        ctrl_mult;
    logic [31:0] data_operandA;
    logic [31:0] data_operandB;
    logic [31:0] data_result;
    logic        data_exception;
    logic        data_resultRDY;
    logic        busy;

    int checks = 0;
    int errors = 0;

    booth_mult_seq #(.WIDTH(32)) dut (
        .clock          (clock),
        .reset_n        (reset_n),
        .ctrl_mult      (ctrl_mult),
        .data_operandA  (data_operandA),
        .data_operandB  (data_operandB),
        .data_result    (data_result),
        .data_exception (data_exception),
        .data_resultRDY (data_resultRDY),
        .busy           (busy)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic start(input logic [31:0] a, input logic [31:0] b);
        @(negedge clock);
        data_operandA = a;
        data_operandB = b;
        ctrl_mult     = 1'b1;
        @(posedge clock);
    endtask

    // hold=0: drop ctrl_mult right after acceptance.
    // hold=1: keep ctrl_mult high with scrambled operands through RUN.
    task automatic wait_rdy(input bit hold, output int cnt, output bit busy_bad);
        cnt      = 0;
        busy_bad = 1'b0;
        do begin
            @(negedge clock);
            cnt++;
            if (cnt < 17 && (busy !== 1'b1 || data_resultRDY !== 1'b0)) busy_bad = 1'b1;
            if (hold && cnt < 16) begin
                data_operandA = $urandom;
                data_operandB = $urandom;
                ctrl_mult     = 1'b1;
            end else begin
                ctrl_mult = 1'b0;
            end
        end while (data_resultRDY !== 1'b1 && cnt < 40);
    endtask

    task automatic run_op(input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] exp_r, input logic exp_e, input string tag);
        int cnt;
        bit busy_bad;
        start(a, b);
        wait_rdy(1'b0, cnt, busy_bad);
        check({tag, "_lat"}, 64'(cnt), 64'd17);
        check({tag, "_busy"}, 64'(busy_bad), 64'd0);
        check({tag, "_res"}, 64'(data_result), 64'(exp_r));
        check({tag, "_exc"}, 64'(data_exception), 64'(exp_e));
        @(negedge clock);
        check({tag, "_rdy_pulse"}, {62'd0, data_resultRDY, busy}, 64'd0);
        check({tag, "_hold"}, {31'd0, data_exception, data_result}, {31'd0, exp_e, exp_r});
    endtask

    initial begin
        int  cnt;
        bit  busy_bad;
        bit  rdy_seen;

        reset_n       = 1'b0;
        ctrl_mult     = 1'b1;
        data_operandA = 32'd9;
        data_operandB = 32'd9;
        repeat (3) @(posedge clock);
        @(negedge clock);
        check("reset_out", {29'd0, data_exception, data_resultRDY, busy, data_result},
              64'd0);
        ctrl_mult = 1'b0;
        reset_n   = 1'b1;

        run_op(32'd3,        32'd5,        32'h0000000F, 1'b0, "3x5");
        run_op(32'hFFFFFFF9, 32'd6,        32'hFFFFFFD6, 1'b0, "m7x6");
        run_op(32'h00010000, 32'h00010000, 32'h00000000, 1'b1, "2p16sq");
        run_op(32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1'b1, "minxm1");
        run_op(32'h80000000, 32'd1,        32'h80000000, 1'b0, "minx1");
        run_op(32'h7FFFFFFF, 32'h7FFFFFFF, 32'h00000001, 1'b1, "maxsq");
        run_op(32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000001, 1'b0, "m1sq");

        start(32'd3, 32'd5);
        wait_rdy(1'b1, cnt, busy_bad);
        check("hold_lat", 64'(cnt), 64'd17);
        check("hold_res", 64'(data_result), 64'h0000000F);

        // Request in the DONE cycle is accepted immediately.
        start(32'h80000000, 32'd1);
        wait_rdy(1'b0, cnt, busy_bad);
        check("b2b_first", 64'(data_result), 64'h80000000);
        data_operandA = 32'd2;
        data_operandB = 32'hFFFFFFFC;
        ctrl_mult     = 1'b1;
        @(posedge clock);
        wait_rdy(1'b0, cnt, busy_bad);
        check("b2b_lat", 64'(cnt), 64'd17);
        check("b2b_res", {31'd0, data_exception, data_result}, 64'h00000000FFFFFFF8);

        start(32'd3, 32'd5);
        for (int k = 1; k <= 8; k++) begin
            @(negedge clock);
            ctrl_mult = 1'b0;
        end
        reset_n = 1'b0;
        @(posedge clock);
        @(negedge clock);
        check("midrun_reset", {29'd0, data_exception, data_resultRDY, busy, data_result},
              64'd0);
        reset_n  = 1'b1;
        rdy_seen = 1'b0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clock);
            if (data_resultRDY === 1'b1) rdy_seen = 1'b1;
        end
        check("no_rdy_after_abort", 64'(rdy_seen), 64'd0);

        // Reset wins over a simultaneous start request.
        @(negedge clock);
        reset_n   = 1'b0;
        ctrl_mult = 1'b1;
        @(posedge clock);
        @(negedge clock);
        check("reset_vs_start", 64'(busy), 64'd0);
        ctrl_mult = 1'b0;
        reset_n   = 1'b1;

        run_op(32'hFFFFFFF9, 32'd6, 32'hFFFFFFD6, 1'b0, "post_reset");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
